// File: rtl/next_pc_unit_pkg.sv
// Shared definitions for the next-address stage: select encodings and default sizes.
package next_pc_unit_pkg;

   typedef enum logic [1:0] {
      SEL_SEQ  = 2'b00,
      SEL_JMP  = 2'b01,
      SEL_CALL = 2'b10,
      SEL_RET  = 2'b11
   } sel_e;

   localparam int AW_DEFAULT    = 8;
   localparam int DEPTH_DEFAULT = 4;

endpackage

// File: rtl/next_pc_unit_ras_stack.sv
// Circular return-address stack: pushing when full overwrites the oldest entry.
module ras_stack #(
   parameter int DEPTH = 4,
   parameter int AW    = 8,
   localparam int PW   = $clog2(DEPTH),
   localparam int DW   = $clog2(DEPTH + 1)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          en,
   input  logic          push,
   input  logic          pop,
   input  logic [AW-1:0] din,
   output logic [AW-1:0] top,
   output logic [DW-1:0] depth,
   output logic          full,
   output logic          empty
);

   logic [AW-1:0] mem [DEPTH];
   logic [PW-1:0] ptr;

   // ptr is the write pointer; DEPTH is a power of two so the wrap is free.
   assign top   = mem[ptr - PW'(1)];
   assign full  = (depth == DW'(DEPTH));
   assign empty = (depth == '0);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ptr   <= '0;
         depth <= '0;
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else if (en) begin
         if (push) begin
            mem[ptr] <= din;
            ptr      <= ptr + PW'(1);
            if (!full) depth <= depth + DW'(1);
         end else if (pop && !empty) begin
            ptr   <= ptr - PW'(1);
            depth <= depth - DW'(1);
         end
      end
   end

endmodule

// File: rtl/next_pc_unit.sv
// Next-address stage: selects sequential, jump, call or return target for the PC load input.
module next_pc_unit
   import next_pc_unit_pkg::*;
#(
   parameter int AW    = AW_DEFAULT,
   parameter int DEPTH = DEPTH_DEFAULT,
   localparam int DW   = $clog2(DEPTH + 1)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          hlt,
   input  logic [AW-1:0] pc_cur,
   input  logic [1:0]    sel,
   input  logic          cond_en,
   input  logic          cond_flag,
   input  logic [AW-1:0] target,
   input  logic          clr_flags,
   output logic [AW-1:0] pc_next,
   output logic [DW-1:0] depth,
   output logic          ras_ovf,
   output logic          ras_unf
);

   logic [AW-1:0] inc;
   logic [AW-1:0] top;
   logic          taken;
   logic          push;
   logic          pop;
   logic          full;
   logic          empty;
   sel_e          sel_q;

   assign sel_q = sel_e'(sel);
   assign inc   = pc_cur + AW'(1);
   assign taken = !cond_en || cond_flag;
   assign push  = (sel_q == SEL_CALL) && taken;
   assign pop   = (sel_q == SEL_RET);

   always_comb begin
      pc_next = inc;
      unique case (sel_q)
         SEL_SEQ:  pc_next = inc;
         SEL_JMP:  pc_next = taken ? target : inc;
         SEL_CALL: pc_next = taken ? target : inc;
         SEL_RET:  pc_next = empty ? inc : top;
         default:  pc_next = inc;
      endcase
   end

   ras_stack #(
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_ras (
      .clk   (clk),
      .reset (reset),
      .en    (!hlt),
      .push  (push),
      .pop   (pop),
      .din   (inc),
      .top   (top),
      .depth (depth),
      .full  (full),
      .empty (empty)
   );

   // A set event in the same cycle as clr_flags takes priority.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ras_ovf <= 1'b0;
         ras_unf <= 1'b0;
      end else if (!hlt) begin
         ras_ovf <= (ras_ovf && !clr_flags) || (push && full);
         ras_unf <= (ras_unf && !clr_flags) || (pop && empty);
      end
   end

endmodule

// File: tb/tb_next_pc_unit.sv
// Directed self-checking bench for next_pc_unit with hand-computed expectations.
module tb_next_pc_unit;
   import next_pc_unit_pkg::*;

   logic       clk = 1'b0;
   logic       reset;
   logic       hlt;
   logic [7:0] pc_cur;
   logic [1:0] sel;
   logic       cond_en;
   logic       cond_flag;
   logic [7:0] target;
   logic       clr_flags;
   logic [7:0] pc_next;
   logic [2:0] depth;
   logic       ras_ovf;
   logic       ras_unf;

   int tests  = 0;
   int failed = 0;

   next_pc_unit #(.AW(8), .DEPTH(4)) dut (
      .clk       (clk),
      .reset     (reset),
      .hlt       (hlt),
      .pc_cur    (pc_cur),
      .sel       (sel),
      .cond_en   (cond_en),
      .cond_flag (cond_flag),
      .target    (target),
      .clr_flags (clr_flags),
      .pc_next   (pc_next),
      .depth     (depth),
      .ras_ovf   (ras_ovf),
      .ras_unf   (ras_unf)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic drive(input logic [1:0] s, input logic [7:0] pc, input logic [7:0] tgt,
                        input logic ce, input logic cf);
      sel = s; pc_cur = pc; target = tgt; cond_en = ce; cond_flag = cf;
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1; hlt = 1'b0; clr_flags = 1'b0;
      drive(SEL_SEQ, 8'h10, 8'h00, 1'b0, 1'b0);
      tests++; if (pc_next !== 8'h11) begin failed++; $display("FAIL reset_pc_next got %h exp 11", pc_next); end
      tests++; if (depth !== 3'd0) begin failed++; $display("FAIL reset_depth got %0d exp 0", depth); end
      tests++; if (ras_ovf !== 1'b0) begin failed++; $display("FAIL reset_ovf got %b exp 0", ras_ovf); end
      tests++; if (ras_unf !== 1'b0) begin failed++; $display("FAIL reset_unf got %b exp 0", ras_unf); end
      @(negedge clk);
      reset = 1'b0;
      step();
   endtask

   task automatic test_seq_jmp();
      drive(SEL_SEQ, 8'hFF, 8'h00, 1'b0, 1'b0);
      tests++; if (pc_next !== 8'h00) begin failed++; $display("FAIL seq_wrap got %h exp 00", pc_next); end
      drive(SEL_JMP, 8'h20, 8'h40, 1'b1, 1'b0);
      tests++; if (pc_next !== 8'h21) begin failed++; $display("FAIL jmp_not_taken got %h exp 21", pc_next); end
      drive(SEL_JMP, 8'h20, 8'h40, 1'b1, 1'b1);
      tests++; if (pc_next !== 8'h40) begin failed++; $display("FAIL jmp_taken got %h exp 40", pc_next); end
      drive(SEL_JMP, 8'h20, 8'h40, 1'b0, 1'b0);
      tests++; if (pc_next !== 8'h40) begin failed++; $display("FAIL jmp_uncond got %h exp 40", pc_next); end
      step();
      tests++; if (depth !== 3'd0) begin failed++; $display("FAIL jmp_depth got %0d exp 0", depth); end
   endtask

   task automatic test_call_ret();
      drive(SEL_CALL, 8'h05, 8'h80, 1'b0, 1'b0);
      tests++; if (pc_next !== 8'h80) begin failed++; $display("FAIL call_pc_next got %h exp 80", pc_next); end
      step();
      tests++; if (depth !== 3'd1) begin failed++; $display("FAIL call_depth got %0d exp 1", depth); end
      drive(SEL_RET, 8'h80, 8'h00, 1'b0, 1'b0);
      tests++; if (pc_next !== 8'h06) begin failed++; $display("FAIL ret_pc_next got %h exp 06", pc_next); end
      step();
      tests++; if (depth !== 3'd0) begin failed++; $display("FAIL ret_depth got %0d exp 0", depth); end
      drive(SEL_CALL, 8'h07, 8'h80, 1'b1, 1'b0);
      tests++; if (pc_next !== 8'h08) begin failed++; $display("FAIL call_not_taken got %h exp 08", pc_next); end
      step();
      tests++; if (depth !== 3'd0) begin failed++; $display("FAIL call_not_taken_depth got %0d exp 0", depth); end
   endtask

   task automatic test_overflow();
      logic [7:0] exp_ret [4];
      exp_ret[0] = 8'h06; exp_ret[1] = 8'h05; exp_ret[2] = 8'h04; exp_ret[3] = 8'h03;
      for (int i = 1; i <= 5; i++) begin
         drive(SEL_CALL, 8'(i), 8'h90, 1'b0, 1'b0);
         step();
         if (i == 4) begin
            tests++; if (ras_ovf !== 1'b0) begin failed++; $display("FAIL ovf_early got %b exp 0", ras_ovf); end
         end
      end
      tests++; if (ras_ovf !== 1'b1) begin failed++; $display("FAIL ovf_set got %b exp 1", ras_ovf); end
      tests++; if (depth !== 3'd4) begin failed++; $display("FAIL ovf_depth got %0d exp 4", depth); end
      for (int i = 0; i < 4; i++) begin
         drive(SEL_RET, 8'h90, 8'h00, 1'b0, 1'b0);
         tests++; if (pc_next !== exp_ret[i]) begin failed++; $display("FAIL ret_order_%0d got %h exp %h", i, pc_next, exp_ret[i]); end
         step();
      end
      tests++; if (depth !== 3'd0) begin failed++; $display("FAIL drain_depth got %0d exp 0", depth); end
      tests++; if (ras_unf !== 1'b0) begin failed++; $display("FAIL unf_early got %b exp 0", ras_unf); end
      drive(SEL_RET, 8'h30, 8'h00, 1'b0, 1'b0);
      tests++; if (pc_next !== 8'h31) begin failed++; $display("FAIL unf_pc_next got %h exp 31", pc_next); end
      step();
      tests++; if (ras_unf !== 1'b1) begin failed++; $display("FAIL unf_set got %b exp 1", ras_unf); end
      tests++; if (depth !== 3'd0) begin failed++; $display("FAIL unf_depth got %0d exp 0", depth); end
      clr_flags = 1'b1;
      drive(SEL_SEQ, 8'h30, 8'h00, 1'b0, 1'b0);
      step();
      clr_flags = 1'b0;
      tests++; if (ras_ovf !== 1'b0 || ras_unf !== 1'b0) begin failed++; $display("FAIL clr got ovf=%b unf=%b exp 0 0", ras_ovf, ras_unf); end
   endtask

   task automatic test_hold();
      drive(SEL_RET, 8'h60, 8'h00, 1'b0, 1'b0);
      step();
      tests++; if (ras_unf !== 1'b1) begin failed++; $display("FAIL hold_pre_unf got %b exp 1", ras_unf); end
      hlt = 1'b1; clr_flags = 1'b1;
      drive(SEL_CALL, 8'h10, 8'h50, 1'b0, 1'b0);
      tests++; if (pc_next !== 8'h50) begin failed++; $display("FAIL hold_pc_next got %h exp 50", pc_next); end
      for (int i = 0; i < 3; i++) begin
         step();
         tests++; if (depth !== 3'd0) begin failed++; $display("FAIL hold_depth_%0d got %0d exp 0", i, depth); end
         tests++; if (ras_unf !== 1'b1) begin failed++; $display("FAIL hold_unf_%0d got %b exp 1", i, ras_unf); end
      end
      hlt = 1'b0; clr_flags = 1'b0;
      step();
      tests++; if (depth !== 3'd1) begin failed++; $display("FAIL unhold_depth got %0d exp 1", depth); end
      drive(SEL_RET, 8'h50, 8'h00, 1'b0, 1'b0);
      tests++; if (pc_next !== 8'h11) begin failed++; $display("FAIL unhold_top got %h exp 11", pc_next); end
   endtask

   task automatic test_clr_vs_ovf();
      clr_flags = 1'b1;
      drive(SEL_SEQ, 8'h00, 8'h00, 1'b0, 1'b0);
      step();
      clr_flags = 1'b0;
      for (int i = 0; i < 3; i++) begin
         drive(SEL_CALL, 8'(8'h20 + i), 8'hA0, 1'b1, 1'b1);
         step();
      end
      tests++; if (depth !== 3'd4 || ras_ovf !== 1'b0) begin failed++; $display("FAIL fill got depth=%0d ovf=%b exp 4 0", depth, ras_ovf); end
      clr_flags = 1'b1;
      drive(SEL_CALL, 8'h23, 8'hA0, 1'b0, 1'b0);
      step();
      clr_flags = 1'b0;
      tests++; if (ras_ovf !== 1'b1) begin failed++; $display("FAIL clr_vs_ovf got %b exp 1", ras_ovf); end
      drive(SEL_RET, 8'hA0, 8'h00, 1'b0, 1'b0);
      tests++; if (pc_next !== 8'h24) begin failed++; $display("FAIL ovf_top got %h exp 24", pc_next); end
      step();
      tests++; if (depth !== 3'd3) begin failed++; $display("FAIL pop_depth got %0d exp 3", depth); end
   endtask

   task automatic test_reset_mid();
      drive(SEL_CALL, 8'h70, 8'h90, 1'b0, 1'b0);
      reset = 1'b1;
      #1;
      tests++; if (depth !== 3'd0) begin failed++; $display("FAIL mid_reset_depth got %0d exp 0", depth); end
      tests++; if (ras_ovf !== 1'b0 || ras_unf !== 1'b0) begin failed++; $display("FAIL mid_reset_flags got ovf=%b unf=%b exp 0 0", ras_ovf, ras_unf); end
      reset = 1'b0;
      drive(SEL_RET, 8'h40, 8'h00, 1'b0, 1'b0);
      tests++; if (pc_next !== 8'h41) begin failed++; $display("FAIL post_reset_ret got %h exp 41", pc_next); end
      step();
      tests++; if (ras_unf !== 1'b1) begin failed++; $display("FAIL post_reset_unf got %b exp 1", ras_unf); end
      tests++; if (depth !== 3'd0) begin failed++; $display("FAIL post_reset_depth got %0d exp 0", depth); end
   endtask

   initial begin
      test_reset();
      test_seq_jmp();
      test_call_ret();
      test_overflow();
      test_hold();
      test_clr_vs_ovf();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
